fifo_ctrl: RTL and testbench

Sequential control core of the 8-entry FIFO. It accepts write and read requests, keeps the storage array, head/tail pointers and occupancy count, and emits the registered `state` and `data_count` codes. The existing `fifo_out` decoder consumes those codes to produce `full`, `empty`, `wr_ack`, `wr_err`, `rd_ack` and `rd_err`. Top-level FIFO = `fifo_ctrl` + `fifo_out`.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_reg_file.sv | 37 +++
 rtl/fifo_ctrl.sv | 64 ++++++
 tb/tb_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO control core and its output decoder.
// Holds the state codes, fixed geometry and the next-state rule.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;

  localparam logic [2:0] ST_INIT   = 3'b000;
  localparam logic [2:0] ST_WRITE  = 3'b001;
  localparam logic [2:0] ST_WR_ERR = 3'b010;
  localparam logic [2:0] ST_NO_OP  = 3'b011;
  localparam logic [2:0] ST_READ   = 3'b100;
  localparam logic [2:0] ST_RD_ERR = 3'b101;

  // Next operation depends only on the requests and current occupancy, never on
  // the current state; a simultaneous write+read is rejected as a no-op.
  function automatic logic [2:0] fifo_next_state(
    input logic             wr,
    input logic             rd,
    input logic [CNT_W-1:0] count
  );
    logic [2:0] nxt;
    nxt = ST_NO_OP;
    if (wr && !rd) begin
      nxt = (count < CNT_W'(FIFO_DEPTH)) ? ST_WRITE : ST_WR_ERR;
    end else if (rd && !wr) begin
      nxt = (count != '0) ? ST_READ : ST_RD_ERR;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_reg_file.sv
// Storage array for the FIFO: one synchronous write port addressed by the tail
// pointer and one combinational read port addressed by the head pointer.
module fifo_reg_file
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] row_sel;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_row_sel
      assign row_sel[gi] = wr_en && (wr_addr == PTR_W'(gi));
    end
  endgenerate

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (row_sel[i]) begin
        mem[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_ctrl.sv
// Sequential control core of the 8-entry FIFO: registered operation code,
// occupancy, head/tail pointers and read-data register around the storage array.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      data_count,
  output logic [PTR_W-1:0]      head,
  output logic [PTR_W-1:0]      tail
);

  logic [2:0]            state_next;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign state_next = fifo_next_state(wr_en, rd_en, data_count);
  // Reset wins over a pending write so the array never sees a partial update.
  assign mem_wr     = !rst && (state_next == ST_WRITE);

  fifo_reg_file #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reg_file (
    .clk     (clk),
    .wr_en   (mem_wr),
    .wr_addr (tail),
    .wr_data (d_in),
    .rd_addr (head),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      data_count <= '0;
      head       <= '0;
      tail       <= '0;
      d_out      <= '0;
    end else begin
      state <= state_next;
      case (state_next)
        ST_WRITE: begin
          tail       <= tail + PTR_W'(1);
          data_count <= data_count + CNT_W'(1);
        end
        ST_READ: begin
          d_out      <= rd_data;
          head       <= head + PTR_W'(1);
          data_count <= data_count - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl: reset, fill, drain, idle and
// simultaneous requests, pointer wrap-around and reset in the middle of traffic.
module tb_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic [2:0]  state;
  logic [3:0]  data_count;
  logic [2:0]  head;
  logic [2:0]  tail;

  int checks;
  int errors;

  fifo_ctrl #(
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .d_in       (d_in),
    .d_out      (d_out),
    .state      (state),
    .data_count (data_count),
    .head       (head),
    .tail       (tail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and settle 1 time unit past the rising edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [31:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    d_in  = d;
    @(posedge clk);
    #1;
    $display("txn rst=%0b wr=%0b rd=%0b d_in=%08h -> state=%03b count=%0d head=%0d tail=%0d d_out=%08h",
             r, w, rd, d, state, data_count, head, tail, d_out);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
      checks++;
      if (state !== 3'b000) begin
        errors++;
        $display("FAIL reset_state: got %03b want 000", state);
      end
      checks++;
      if (data_count !== 4'd0 || head !== 3'd0 || tail !== 3'd0) begin
        errors++;
        $display("FAIL reset_ptrs: got count=%0d head=%0d tail=%0d want 0/0/0", data_count, head, tail);
      end
      checks++;
      if (d_out !== 32'h0) begin
        errors++;
        $display("FAIL reset_dout: got %08h want 00000000", d_out);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] v;
    for (int i = 1; i <= 8; i++) begin
      v = 32'h11 * i;
      step(1'b0, 1'b1, 1'b0, v);
      checks++;
      if (state !== 3'b001 || data_count !== 4'(i) || tail !== 3'(i % 8)) begin
        errors++;
        $display("FAIL fill_%0d: got state=%03b count=%0d tail=%0d want 001/%0d/%0d",
                 i, state, data_count, tail, i, i % 8);
      end
    end
    step(1'b0, 1'b1, 1'b0, 32'h99);
    checks++;
    if (state !== 3'b010 || data_count !== 4'd8 || tail !== 3'd0) begin
      errors++;
      $display("FAIL fill_overflow: got state=%03b count=%0d tail=%0d want 010/8/0", state, data_count, tail);
    end
  endtask

  task automatic test_drain();
    logic [31:0] v;
    for (int i = 1; i <= 8; i++) begin
      v = 32'h11 * i;
      step(1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (state !== 3'b100 || d_out !== v || data_count !== 4'(8 - i) || head !== 3'(i % 8)) begin
        errors++;
        $display("FAIL drain_%0d: got state=%03b d_out=%08h count=%0d head=%0d want 100/%08h/%0d/%0d",
                 i, state, d_out, data_count, head, v, 8 - i, i % 8);
      end
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (state !== 3'b101 || d_out !== 32'h88 || data_count !== 4'd0 || head !== 3'd0) begin
      errors++;
      $display("FAIL drain_underflow: got state=%03b d_out=%08h count=%0d head=%0d want 101/00000088/0/0",
               state, d_out, data_count, head);
    end
  endtask

  task automatic test_idle_simultaneous();
    step(1'b0, 1'b1, 1'b0, 32'hA1);
    step(1'b0, 1'b1, 1'b0, 32'hA2);
    step(1'b0, 1'b1, 1'b0, 32'hA3);
    step(1'b0, 1'b1, 1'b1, 32'hFF);
    checks++;
    if (state !== 3'b011 || data_count !== 4'd3 || head !== 3'd0 || tail !== 3'd3 || d_out !== 32'h88) begin
      errors++;
      $display("FAIL simultaneous: got state=%03b count=%0d head=%0d tail=%0d d_out=%08h want 011/3/0/3/00000088",
               state, data_count, head, tail, d_out);
    end
    step(1'b0, 1'b0, 1'b0, 32'hFF);
    checks++;
    if (state !== 3'b011 || data_count !== 4'd3 || head !== 3'd0 || tail !== 3'd3 || d_out !== 32'h88) begin
      errors++;
      $display("FAIL idle: got state=%03b count=%0d head=%0d tail=%0d d_out=%08h want 011/3/0/3/00000088",
               state, data_count, head, tail, d_out);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (d_out !== (32'hA0 + i) || data_count !== 4'(3 - i)) begin
        errors++;
        $display("FAIL idle_read_%0d: got d_out=%08h count=%0d want %08h/%0d",
                 i, d_out, data_count, 32'hA0 + i, 3 - i);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q [$];
    logic [31:0] v;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      v = 32'hB0 + i;
      step(1'b0, 1'b1, 1'b0, v);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
    end
    checks++;
    if (d_out !== 32'hB4 || head !== 3'd5) begin
      errors++;
      $display("FAIL wrap_first_reads: got d_out=%08h head=%0d want 000000b4/5", d_out, head);
    end
    for (int i = 0; i < 6; i++) begin
      v = 32'hC0 + i;
      step(1'b0, 1'b1, 1'b0, v);
    end
    checks++;
    if (data_count !== 4'd7 || tail !== 3'd4 || head !== 3'd5) begin
      errors++;
      $display("FAIL wrap_ptrs: got count=%0d tail=%0d head=%0d want 7/4/5", data_count, tail, head);
    end
    exp_q = '{32'hB5, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (state !== 3'b100 || d_out !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_read_%0d: got state=%03b d_out=%08h want 100/%08h", i, state, d_out, exp_q[i]);
      end
    end
    checks++;
    if (data_count !== 4'd0 || head !== 3'd4) begin
      errors++;
      $display("FAIL wrap_empty: got count=%0d head=%0d want 0/4", data_count, head);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 32'hD0 + i;
      step(1'b0, 1'b1, 1'b0, v);
    end
    checks++;
    if (data_count !== 4'd4 || tail !== 3'd0) begin
      errors++;
      $display("FAIL mid_setup: got count=%0d tail=%0d want 4/0", data_count, tail);
    end
    step(1'b1, 1'b1, 1'b0, 32'hEE);
    checks++;
    if (state !== 3'b000 || data_count !== 4'd0 || head !== 3'd0 || tail !== 3'd0 || d_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got state=%03b count=%0d head=%0d tail=%0d d_out=%08h want 000/0/0/0/00000000",
               state, data_count, head, tail, d_out);
    end
    // Slot 0 was the write target at the reset edge and must keep its old value.
    checks++;
    if (dut.u_reg_file.mem[0] !== 32'hC2) begin
      errors++;
      $display("FAIL mid_mem_untouched: got %08h want 000000c2", dut.u_reg_file.mem[0]);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (state !== 3'b101 || data_count !== 4'd0 || head !== 3'd0 || d_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_read_after_reset: got state=%03b count=%0d head=%0d d_out=%08h want 101/0/0/00000000",
               state, data_count, head, d_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    d_in   = 32'h0;
    test_reset();
    test_fill();
    test_drain();
    test_idle_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
